// File: rtl/rep_wb_pkg.sv
// Shared types for the REP/REPE/REPNE writeback controller.
//   rep_state_e : controller state encoding
//   REP_*       : REP_MODE field encodings
package rep_wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      TERM = 2'b10,
      HALT = 2'b11
   } rep_state_e;

   localparam int unsigned REP_MODE_W = 2;

   localparam logic [REP_MODE_W-1:0] REP_NONE  = 2'b00;
   localparam logic [REP_MODE_W-1:0] REP_REP   = 2'b01;
   localparam logic [REP_MODE_W-1:0] REP_REPE  = 2'b10;
   localparam logic [REP_MODE_W-1:0] REP_REPNE = 2'b11;

endpackage

// File: rtl/rep_string_ctrl_wb_if.sv
// WB-side bus of the string-instruction controller.
//   master : WB pipeline side (drives qualifiers/operands, observes results)
//   slave  : rep_string_ctrl_wb
interface rep_string_ctrl_wb_if #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned EIP_W = 32,
   parameter int unsigned CS_W  = 16
);
   import rep_wb_pkg::*;

   logic                  WB_V;
   logic                  FLUSH;
   logic                  START;
   logic [REP_MODE_W-1:0] REP_MODE;
   logic [CNT_W-1:0]      COUNT_IN;
   logic                  ITER_DONE;
   logic                  IS_CMP;
   logic                  ZF;
   logic                  IS_HALT;
   logic [EIP_W-1:0]      NEIP;
   logic [CS_W-1:0]       NCS;

   logic                  BUSY;
   logic                  LD_COUNT;
   logic [CNT_W-1:0]      COUNT_OUT;
   logic                  REISSUE;
   logic                  TERMINATE;
   logic                  LD_EIP;
   logic [EIP_W-1:0]      FINAL_EIP;
   logic [CS_W-1:0]       FINAL_CS;
   logic                  HALT_ALL;
   logic [31:0]           PERF_ITERS;

   modport master (
      output WB_V, FLUSH, START, REP_MODE, COUNT_IN, ITER_DONE, IS_CMP, ZF,
             IS_HALT, NEIP, NCS,
      input  BUSY, LD_COUNT, COUNT_OUT, REISSUE, TERMINATE, LD_EIP,
             FINAL_EIP, FINAL_CS, HALT_ALL, PERF_ITERS
   );

   modport slave (
      input  WB_V, FLUSH, START, REP_MODE, COUNT_IN, ITER_DONE, IS_CMP, ZF,
             IS_HALT, NEIP, NCS,
      output BUSY, LD_COUNT, COUNT_OUT, REISSUE, TERMINATE, LD_EIP,
             FINAL_EIP, FINAL_CS, HALT_ALL, PERF_ITERS
   );

endinterface

// File: rtl/rep_string_ctrl_wb_term_check.sv
// Combinational per-iteration count decrement and termination test.
//   cnt_i      : current count
//   mode_i     : latched REP mode
//   is_cmp_i   : iteration is CMPS/SCAS
//   zf_i       : ZF produced by the iteration
//   cnt_nxt_o  : cnt_i - 1 (wraps)
//   term_o     : instruction completes after this iteration
module rep_term_check
   import rep_wb_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic [CNT_W-1:0]      cnt_i,
   input  logic [REP_MODE_W-1:0] mode_i,
   input  logic                  is_cmp_i,
   input  logic                  zf_i,
   output logic [CNT_W-1:0]      cnt_nxt_o,
   output logic                  term_o
);

   // ZF tests only apply to compare iterations; otherwise REPE/REPNE act as REP.
   always_comb begin
      cnt_nxt_o = cnt_i - CNT_W'(1);
      term_o    = (cnt_nxt_o == '0)
                | (is_cmp_i & (mode_i == REP_REPE)  & ~zf_i)
                | (is_cmp_i & (mode_i == REP_REPNE) &  zf_i);
   end

endmodule

// File: rtl/rep_string_ctrl_wb.sv
// Writeback-stage controller for REP/REPE/REPNE string instructions.
// Latches count and next EIP/CS at START, decrements per retired iteration,
// decides termination, issues a one-cycle EIP/CS redirect and holds a sticky
// halt. All bus outputs are registered.
// Ports:
//   CLK : clock
//   CLR : synchronous active-high reset
//   bus : rep_string_ctrl_wb_if.slave (WB qualifiers in, control/redirect out)
// Optional feature: define REP_PERF_CNT_EN to build the 32-bit saturating
// retired-iteration counter on PERF_ITERS; otherwise PERF_ITERS is tied to 0.
module rep_string_ctrl_wb
   import rep_wb_pkg::*;
#(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned EIP_W = 32,
   parameter int unsigned CS_W  = 16
) (
   input  logic                 CLK,
   input  logic                 CLR,
   rep_string_ctrl_wb_if.slave  bus
);

   rep_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [REP_MODE_W-1:0] mode_q, mode_d;
   logic [EIP_W-1:0]      eip_q, eip_d;
   logic [CS_W-1:0]       cs_q, cs_d;

   logic                  busy_q, busy_d;
   logic                  ld_count_q, ld_count_d;
   logic [CNT_W-1:0]      count_out_q, count_out_d;
   logic                  reissue_q, reissue_d;
   logic                  terminate_q, terminate_d;
   logic                  ld_eip_q, ld_eip_d;
   logic [EIP_W-1:0]      final_eip_q, final_eip_d;
   logic [CS_W-1:0]       final_cs_q, final_cs_d;
   logic                  halt_q, halt_d;

   logic [CNT_W-1:0]      cnt_nxt_c;
   logic                  term_c;

   // WB_V-qualified strobes
   logic start_c, iter_c, flush_c, halt_req_c;
   assign start_c    = bus.WB_V & bus.START;
   assign iter_c     = bus.WB_V & bus.ITER_DONE;
   assign flush_c    = bus.WB_V & bus.FLUSH;
   assign halt_req_c = bus.WB_V & bus.IS_HALT;

   rep_term_check #(.CNT_W(CNT_W)) u_term_check (
      .cnt_i     (cnt_q),
      .mode_i    (mode_q),
      .is_cmp_i  (bus.IS_CMP),
      .zf_i      (bus.ZF),
      .cnt_nxt_o (cnt_nxt_c),
      .term_o    (term_c)
   );

   // State and output registers
   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mode_q      <= REP_NONE;
         eip_q       <= '0;
         cs_q        <= '0;
         busy_q      <= 1'b0;
         ld_count_q  <= 1'b0;
         count_out_q <= '0;
         reissue_q   <= 1'b0;
         terminate_q <= 1'b0;
         ld_eip_q    <= 1'b0;
         final_eip_q <= '0;
         final_cs_q  <= '0;
         halt_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         eip_q       <= eip_d;
         cs_q        <= cs_d;
         busy_q      <= busy_d;
         ld_count_q  <= ld_count_d;
         count_out_q <= count_out_d;
         reissue_q   <= reissue_d;
         terminate_q <= terminate_d;
         ld_eip_q    <= ld_eip_d;
         final_eip_q <= final_eip_d;
         final_cs_q  <= final_cs_d;
         halt_q      <= halt_d;
      end
   end

   // Next state; pulse outputs are computed on the transition so they line up
   // with the state they belong to.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      eip_d       = eip_q;
      cs_d        = cs_q;
      ld_count_d  = 1'b0;
      count_out_d = count_out_q;
      reissue_d   = 1'b0;
      terminate_d = 1'b0;
      ld_eip_d    = 1'b0;
      final_eip_d = '0;
      final_cs_d  = '0;
      halt_d      = halt_q;

      unique case (state_q)
         IDLE: begin
            if (halt_req_c) begin
               state_d = HALT;
               halt_d  = 1'b1;
            end else if (start_c && (bus.REP_MODE != REP_NONE)) begin
               cnt_d  = bus.COUNT_IN;
               mode_d = bus.REP_MODE;
               eip_d  = bus.NEIP;
               cs_d   = bus.NCS;
               if (bus.COUNT_IN != '0) begin
                  state_d = RUN;
               end else begin
                  // zero iterations: redirect straight away
                  state_d     = TERM;
                  terminate_d = 1'b1;
                  ld_eip_d    = 1'b1;
                  final_eip_d = bus.NEIP;
                  final_cs_d  = bus.NCS;
               end
            end
         end
         RUN: begin
            // flush aborts the in-flight iteration, including its count write
            if (flush_c) begin
               state_d = IDLE;
            end else if (iter_c) begin
               cnt_d       = cnt_nxt_c;
               ld_count_d  = 1'b1;
               count_out_d = cnt_nxt_c;
               if (term_c) begin
                  state_d     = TERM;
                  terminate_d = 1'b1;
                  ld_eip_d    = 1'b1;
                  final_eip_d = eip_q;
                  final_cs_d  = cs_q;
               end else begin
                  reissue_d = 1'b1;
               end
            end
         end
         TERM: begin
            state_d = IDLE;
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN) || (state_d == TERM);
   end

   assign bus.BUSY      = busy_q;
   assign bus.LD_COUNT  = ld_count_q;
   assign bus.COUNT_OUT = count_out_q;
   assign bus.REISSUE   = reissue_q;
   assign bus.TERMINATE = terminate_q;
   assign bus.LD_EIP    = ld_eip_q;
   assign bus.FINAL_EIP = final_eip_q;
   assign bus.FINAL_CS  = final_cs_q;
   assign bus.HALT_ALL  = halt_q;

`ifdef REP_PERF_CNT_EN
   // Saturating count of iterations that actually retired (not flushed)
   logic [31:0] perf_q, perf_d;
   logic        perf_inc_c;

   assign perf_inc_c = (state_q == RUN) & iter_c & ~flush_c;

   always_comb begin
      perf_d = perf_q;
      if (perf_inc_c && (perf_q != 32'hFFFF_FFFF)) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign bus.PERF_ITERS = perf_q;
`else
   assign bus.PERF_ITERS = '0;
`endif

endmodule

// File: tb/tb_rep_string_ctrl_wb.sv
// Directed self-checking bench for rep_string_ctrl_wb (CNT_W=16).
// Inputs change #1 after a rising edge; outputs are checked #1 after the
// following rising edge, so each check sees the registers loaded at that edge.
module tb_rep_string_ctrl_wb;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned EIP_W = 32;
   localparam int unsigned CS_W  = 16;

   logic CLK;
   logic CLR;

   int n_chk  = 0;
   int n_fail = 0;

   rep_string_ctrl_wb_if #(.CNT_W(CNT_W), .EIP_W(EIP_W), .CS_W(CS_W)) bus ();

   rep_string_ctrl_wb #(.CNT_W(CNT_W), .EIP_W(EIP_W), .CS_W(CS_W)) dut (
      .CLK (CLK),
      .CLR (CLR),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [1:0] mode, input logic [15:0] cnt,
                        input logic [31:0] eip, input logic [15:0] cs);
      bus.START    = 1'b1;
      bus.REP_MODE = mode;
      bus.COUNT_IN = cnt;
      bus.NEIP     = eip;
      bus.NCS      = cs;
      tick();
      bus.START    = 1'b0;
      bus.REP_MODE = 2'b00;
      bus.COUNT_IN = 16'hFFFF;
      bus.NEIP     = 32'hDEAD_BEEF;
      bus.NCS      = 16'hBAD0;
   endtask

   logic [31:0] perf_mid_exp;
   logic [31:0] perf_end_exp;

   initial begin
`ifdef REP_PERF_CNT_EN
      perf_mid_exp = 32'd7;
      perf_end_exp = 32'd2;
`else
      perf_mid_exp = 32'd0;
      perf_end_exp = 32'd0;
`endif
      CLR          = 1'b1;
      bus.WB_V     = 1'b1;
      bus.FLUSH    = 1'b0;
      bus.START    = 1'b0;
      bus.REP_MODE = 2'b00;
      bus.COUNT_IN = '0;
      bus.ITER_DONE = 1'b0;
      bus.IS_CMP   = 1'b0;
      bus.ZF       = 1'b0;
      bus.IS_HALT  = 1'b0;
      bus.NEIP     = '0;
      bus.NCS      = '0;
      tick();
      tick();

      // reset state
      chk("rst_busy",      64'(bus.BUSY), 64'd0);
      chk("rst_term",      64'(bus.TERMINATE), 64'd0);
      chk("rst_ldeip",     64'(bus.LD_EIP), 64'd0);
      chk("rst_count_out", 64'(bus.COUNT_OUT), 64'd0);
      chk("rst_final_eip", 64'(bus.FINAL_EIP), 64'd0);
      chk("rst_final_cs",  64'(bus.FINAL_CS), 64'd0);
      chk("rst_halt",      64'(bus.HALT_ALL), 64'd0);
      chk("rst_perf",      64'(bus.PERF_ITERS), 64'd0);
      CLR = 1'b0;
      tick();

      // REP, count 3, back-to-back iterations
      start(2'b01, 16'd3, 32'h1000_0010, 16'h0008);
      chk("rep_busy",   64'(bus.BUSY), 64'd1);
      chk("rep_ld0",    64'(bus.LD_COUNT), 64'd0);
      bus.ITER_DONE = 1'b1;
      tick();
      chk("rep_ld1",    64'(bus.LD_COUNT), 64'd1);
      chk("rep_cnt1",   64'(bus.COUNT_OUT), 64'd2);
      chk("rep_reis1",  64'(bus.REISSUE), 64'd1);
      chk("rep_term1",  64'(bus.TERMINATE), 64'd0);
      tick();
      chk("rep_cnt2",   64'(bus.COUNT_OUT), 64'd1);
      chk("rep_reis2",  64'(bus.REISSUE), 64'd1);
      tick();
      chk("rep_cnt3",   64'(bus.COUNT_OUT), 64'd0);
      chk("rep_ld3",    64'(bus.LD_COUNT), 64'd1);
      chk("rep_reis3",  64'(bus.REISSUE), 64'd0);
      chk("rep_term3",  64'(bus.TERMINATE), 64'd1);
      chk("rep_ldeip3", 64'(bus.LD_EIP), 64'd1);
      chk("rep_feip",   64'(bus.FINAL_EIP), 64'h1000_0010);
      chk("rep_fcs",    64'(bus.FINAL_CS), 64'h0008);
      chk("rep_busy3",  64'(bus.BUSY), 64'd1);
      bus.ITER_DONE = 1'b0;
      tick();
      chk("rep_term4",  64'(bus.TERMINATE), 64'd0);
      chk("rep_ldeip4", 64'(bus.LD_EIP), 64'd0);
      chk("rep_ld4",    64'(bus.LD_COUNT), 64'd0);
      chk("rep_busy4",  64'(bus.BUSY), 64'd0);

      // REPNE CMPS, count 10, ZF set on 2nd iteration
      start(2'b11, 16'd10, 32'h0000_2000, 16'h1234);
      bus.ITER_DONE = 1'b1;
      bus.IS_CMP    = 1'b1;
      bus.ZF        = 1'b0;
      tick();
      chk("rpne_cnt1",  64'(bus.COUNT_OUT), 64'd9);
      chk("rpne_reis1", 64'(bus.REISSUE), 64'd1);
      chk("rpne_term1", 64'(bus.TERMINATE), 64'd0);
      bus.ZF = 1'b1;
      tick();
      chk("rpne_cnt2",  64'(bus.COUNT_OUT), 64'd8);
      chk("rpne_reis2", 64'(bus.REISSUE), 64'd0);
      chk("rpne_term2", 64'(bus.TERMINATE), 64'd1);
      chk("rpne_feip",  64'(bus.FINAL_EIP), 64'h0000_2000);
      chk("rpne_fcs",   64'(bus.FINAL_CS), 64'h1234);
      bus.ZF = 1'b0;
      tick();
      chk("rpne_ld3",   64'(bus.LD_COUNT), 64'd0);
      chk("rpne_busy3", 64'(bus.BUSY), 64'd0);
      bus.ITER_DONE = 1'b0;
      bus.IS_CMP    = 1'b0;

      // REPE, count 0, started right after the previous TERM
      start(2'b10, 16'd0, 32'h0000_3000, 16'h0055);
      chk("z_term",  64'(bus.TERMINATE), 64'd1);
      chk("z_ldeip", 64'(bus.LD_EIP), 64'd1);
      chk("z_ld",    64'(bus.LD_COUNT), 64'd0);
      chk("z_fcs",   64'(bus.FINAL_CS), 64'h0055);
      chk("z_feip",  64'(bus.FINAL_EIP), 64'h0000_3000);
      chk("z_busy",  64'(bus.BUSY), 64'd1);
      tick();
      chk("z_term2", 64'(bus.TERMINATE), 64'd0);
      chk("z_ld2",   64'(bus.LD_COUNT), 64'd0);
      chk("z_busy2", 64'(bus.BUSY), 64'd0);

      // REP_MODE none is ignored
      start(2'b00, 16'd5, 32'h0000_4000, 16'h0001);
      chk("none_busy", 64'(bus.BUSY), 64'd0);
      chk("none_term", 64'(bus.TERMINATE), 64'd0);

      // REP count 5: unqualified ITER_DONE, then FLUSH with the 2nd iteration
      start(2'b01, 16'd5, 32'h0000_5000, 16'h0002);
      bus.WB_V      = 1'b0;
      bus.ITER_DONE = 1'b1;
      tick();
      chk("fl_novalid", 64'(bus.LD_COUNT), 64'd0);
      bus.WB_V = 1'b1;
      tick();
      chk("fl_ld1",   64'(bus.LD_COUNT), 64'd1);
      chk("fl_cnt1",  64'(bus.COUNT_OUT), 64'd4);
      bus.FLUSH = 1'b1;
      tick();
      chk("fl_ld2",   64'(bus.LD_COUNT), 64'd0);
      chk("fl_cnt2",  64'(bus.COUNT_OUT), 64'd4);
      chk("fl_busy",  64'(bus.BUSY), 64'd0);
      chk("fl_term",  64'(bus.TERMINATE), 64'd0);
      chk("fl_reis",  64'(bus.REISSUE), 64'd0);
      bus.FLUSH     = 1'b0;
      bus.ITER_DONE = 1'b0;
      tick();
      chk("fl_term2", 64'(bus.TERMINATE), 64'd0);
      chk("fl_ldeip", 64'(bus.LD_EIP), 64'd0);

      // REPE CMPS with ZF clear ends early; IS_CMP=0 would have continued
      start(2'b10, 16'd4, 32'h0000_6000, 16'h0003);
      bus.ITER_DONE = 1'b1;
      bus.IS_CMP    = 1'b1;
      bus.ZF        = 1'b0;
      tick();
      chk("rpe_cnt",  64'(bus.COUNT_OUT), 64'd3);
      chk("rpe_term", 64'(bus.TERMINATE), 64'd1);
      chk("rpe_reis", 64'(bus.REISSUE), 64'd0);
      bus.ITER_DONE = 1'b0;
      bus.IS_CMP    = 1'b0;
      tick();
      chk("perf_mid", 64'(bus.PERF_ITERS), 64'(perf_mid_exp));

      // sticky halt
      bus.IS_HALT = 1'b1;
      tick();
      bus.IS_HALT = 1'b0;
      chk("h_halt", 64'(bus.HALT_ALL), 64'd1);
      chk("h_busy", 64'(bus.BUSY), 64'd0);
      start(2'b01, 16'd3, 32'h0000_7000, 16'h0004);
      chk("h_start_busy", 64'(bus.BUSY), 64'd0);
      chk("h_halt2",      64'(bus.HALT_ALL), 64'd1);
      tick();
      chk("h_halt3",      64'(bus.HALT_ALL), 64'd1);
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      chk("h_clr",      64'(bus.HALT_ALL), 64'd0);
      chk("h_clr_perf", 64'(bus.PERF_ITERS), 64'd0);

      // CLR in the middle of RUN
      start(2'b01, 16'd5, 32'h0000_8000, 16'h0005);
      bus.ITER_DONE = 1'b1;
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      bus.ITER_DONE = 1'b0;
      chk("cr_busy",  64'(bus.BUSY), 64'd0);
      chk("cr_ld",    64'(bus.LD_COUNT), 64'd0);
      chk("cr_term",  64'(bus.TERMINATE), 64'd0);
      tick();
      chk("cr_ldeip", 64'(bus.LD_EIP), 64'd0);

      // two single-iteration instructions
      for (int k = 0; k < 2; k++) begin
         start(2'b01, 16'h0001, 32'h0000_9000, 16'h0006);
         bus.ITER_DONE = 1'b1;
         tick();
         bus.ITER_DONE = 1'b0;
         chk("one_term", 64'(bus.TERMINATE), 64'd1);
         chk("one_cnt",  64'(bus.COUNT_OUT), 64'd0);
         tick();
      end
      chk("perf_end", 64'(bus.PERF_ITERS), 64'(perf_end_exp));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rep_string_ctrl_wb.md
# rep_string_ctrl_wb

Parametrised writeback-stage controller for REP/REPE/REPNE string instructions. Generalises the single-mode REPNE terminate and halt logic into a registered state machine with these capabilities:
- latches the iteration count and the post-instruction EIP/CS at the first uop;
- decrements the count on every retired iteration;
- evaluates mode-specific termination;
- drives a one-cycle EIP/CS redirect on completion;
- holds a sticky halt.

It sits beside operand selection and flags update in WB and feeds the EIP/CS load path and the fetch-side re-issue request.

## Interface
- CNT_W, 32, width of the count register (ECX/CX slice)
- EIP_W, 32, width of saved next-EIP
- CS_W, 16, width of saved next-CS

Clock and reset are fixed:
- CLK  in  1  clock
- CLR  in  1  reset, synchronous, active-high

Inputs:
- WB_V  in  1  WB stage valid
- FLUSH  in  1  pipeline flush (interrupt/exception), aborts iteration
- START  in  1  first uop of a string instruction is in WB
- REP_MODE  in  2  00 none, 01 REP, 10 REPE, 11 REPNE; sampled with START
- COUNT_IN  in  CNT_W  count value at START
- ITER_DONE  in  1  last uop of one iteration is in WB
- IS_CMP  in  1  iteration is CMPS/SCAS (ZF test applies)
- ZF  in  1  zero flag produced by this iteration
- IS_HALT  in  1  HLT uop in WB
- NEIP  in  EIP_W  next-EIP of the string instruction
- NCS  in  CS_W  next-CS

Outputs:
- BUSY  out  1  iteration in progress
- LD_COUNT  out  1  write COUNT_OUT to the count register
- COUNT_OUT  out  CNT_W  decremented count
- REISSUE  out  1  request re-fetch of the same instruction
- TERMINATE  out  1  instruction complete
- LD_EIP  out  1  load FINAL_EIP/FINAL_CS
- FINAL_EIP  out  EIP_W  saved NEIP
- FINAL_CS  out  CS_W  saved NCS
- HALT_ALL  out  1  sticky halt
- PERF_ITERS  out  32  retired iterations (see Configuration)

## Operation
States: IDLE, RUN, TERM, HALT. All inputs are qualified by WB_V.

IDLE:
- IS_HALT → HALT.
- START with REP_MODE≠00 and COUNT_IN≠0 → latch count, NEIP, NCS, mode → RUN.
- START with REP_MODE≠00 and COUNT_IN==0 → latch NEIP/NCS → TERM; zero iterations, no LD_COUNT.
- START with REP_MODE==00 → ignored; the normal EIP path handles it.

RUN, on ITER_DONE:
- cnt_nxt = cnt − 1, modulo 2^CNT_W.
- LD_COUNT pulses with COUNT_OUT=cnt_nxt.
- Terminate when any of:
  - cnt_nxt==0
  - IS_CMP & REPE & ~ZF
  - IS_CMP & REPNE & ZF
- Terminate → TERM. Otherwise REISSUE pulses and the state stays RUN.

RUN, other rules:
- FLUSH → IDLE with no TERMINATE. Counts already written stay architectural.
- FLUSH wins over a same-cycle ITER_DONE; no LD_COUNT is issued for that iteration.
- START or IS_HALT while in RUN is a protocol violation and is ignored.

TERM:
- TERMINATE=1, LD_EIP=1, FINAL_EIP/FINAL_CS = saved values for exactly one cycle → IDLE.
- FLUSH in TERM has no effect; the redirect is still issued.

HALT:
- HALT_ALL=1, all other inputs ignored; exits only on CLR.

IS_CMP=0 with REPE/REPNE behaves as REP.

## Timing
- All outputs are registered.
- Reset values (CLR): state IDLE; all outputs 0, including the saved count, EIP and CS.
- START at cycle N → BUSY=1 at N+1.
- ITER_DONE at N → LD_COUNT/COUNT_OUT and REISSUE, or TERM entry, at N+1.
- TERMINATE/LD_EIP asserted at N+1 for one cycle; BUSY deasserts at N+2.
- Back-to-back ITER_DONE on consecutive cycles is supported: one decrement per cycle, no bubbles.
- START the cycle after TERM (state IDLE) is accepted.
- CLR mid-RUN: back to IDLE at the next edge; no TERMINATE or LD_EIP.

## Configuration
- REP_PERF_CNT_EN defined: PERF_ITERS is a 32-bit saturating counter.
  - Increments once per accepted ITER_DONE in RUN.
  - Cleared by CLR.
  - Holds at 32'hFFFF_FFFF once reached.
- REP_PERF_CNT_EN undefined: PERF_ITERS is tied to 0 and no counter flops are built.

## Structure
- Shared package rep_wb_pkg holds:
  - state encoding: IDLE=2'b00, RUN=2'b01, TERM=2'b10, HALT=2'b11;
  - REP_MODE constants: REP_NONE, REP_REP, REP_REPE, REP_REPNE.
- One sub-module, rep_term_check (combinational, parametrised by CNT_W):
  - inputs: cnt, mode, IS_CMP, ZF;
  - outputs: cnt_nxt and term.

## Test plan
- REP, COUNT_IN=3, ITER_DONE on three consecutive cycles → COUNT_OUT 2, 1, 0; REISSUE twice; TERMINATE+LD_EIP one cycle later with FINAL_EIP=NEIP latched at START.
- REPNE CMPS, COUNT_IN=10, ZF=1 on the 2nd iteration → COUNT_OUT 9 then 8, then TERMINATE; no further LD_COUNT.
- REPE, COUNT_IN=0 → TERM the cycle after START, LD_COUNT never asserted, FINAL_CS=NCS.
- RUN with COUNT_IN=5, FLUSH coincident with the 2nd ITER_DONE → only COUNT_OUT=4 written, IDLE next, TERMINATE never asserted.
- IS_HALT in IDLE → HALT_ALL=1 sticky; START with REP_MODE=01 is ignored; CLR → HALT_ALL=0.
- With REP_PERF_CNT_EN, CNT_W=16, COUNT_IN=16'h0001 twice → PERF_ITERS=2. Without the macro → PERF_ITERS=0.
